// File: rtl/stack_control_pkg.sv
// Shared types and constants for the block-stacker sequencing controller.
package stack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WAIT,
    ST_ERASE,
    ST_STEP,
    ST_LOCK,
    ST_END
  } state_t;

  localparam int BLK_PIX        = 16;   // pixels in the 4x4 block
  localparam int Y_BASE         = 119;  // y of the bottom row
  localparam int ROW_H          = 4;    // rows climb by one block height
  localparam int MAX_LEVEL_DEF  = 29;   // top row sits at y = 3
  localparam int SPEED_INIT_DEF = 8;    // frames per step at level 0

  // Frames per step for a level, floored at one frame.
  function automatic logic [7:0] calc_speed(input logic [7:0] init,
                                            input logic [5:0] level);
    logic [7:0] lvl8;
    lvl8 = {2'b00, level};
    if (init > lvl8) return init - lvl8;
    else             return 8'd1;
  endfunction

endpackage

// File: rtl/stack_control_if.sv
// Key/frame inputs and datapath/VGA outputs of the stack controller.
interface stack_if;
  logic       start;
  logic       stop_btn;
  logic       frame_tick;
  logic [7:0] x_curr;
  logic       step;
  logic       colour_erase_enable;
  logic       plot;
  logic [3:0] offset;
  logic [5:0] curr_level;
  logic       game_over;
  logic       win;
  logic       busy;

  // Controller side: sequences the datapath.
  modport master (
    input  start, stop_btn, frame_tick, x_curr,
    output step, colour_erase_enable, plot, offset, curr_level,
           game_over, win, busy
  );

  // Environment side: keys, frame timer and position register.
  modport slave (
    output start, stop_btn, frame_tick, x_curr,
    input  step, colour_erase_enable, plot, offset, curr_level,
           game_over, win, busy
  );
endinterface

// File: rtl/stack_control_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after the input rises.
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  // Remember last sample and flag a low-to-high change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/stack_control.sv
// Sequencing controller for the block stacker: draw, wait frames, erase,
// step, and lock/level handling with win and game-over detection.
module stack_control
  import stack_pkg::*;
#(
  parameter int SPEED_INIT = SPEED_INIT_DEF,
  parameter int MAX_LEVEL  = MAX_LEVEL_DEF
) (
  input  logic   clk,
  input  logic   resetn,
  stack_if.master bus
);

  state_t     state_q;
  logic [3:0] offset_q;
  logic [5:0] level_q;
  logic [7:0] prev_x_q;
  logic [7:0] fcnt_q;
  logic       stop_pend_q;
  logic       step_q;
  logic       plot_q;
  logic       cee_q;
  logic       game_over_q;
  logic       win_q;
  logic       busy_q;

  logic       stop_rise;
  logic       start_rise;
  logic [7:0] speed;
  logic [8:0] fcnt_inc;
  logic       aligned;
  logic       last_pix;

  edge_detect u_stop_edge (
    .clk    (clk),
    .resetn (resetn),
    .sig_i  (bus.stop_btn),
    .rise_o (stop_rise)
  );

  edge_detect u_start_edge (
    .clk    (clk),
    .resetn (resetn),
    .sig_i  (bus.start),
    .rise_o (start_rise)
  );

  assign speed    = calc_speed(8'(SPEED_INIT), level_q);
  assign fcnt_inc = {1'b0, fcnt_q} + 9'd1;
  // Level 0 has nothing below it, so any position is a valid landing.
  assign aligned  = (level_q == 6'd0) || (bus.x_curr == prev_x_q);
  assign last_pix = (offset_q == 4'(BLK_PIX - 1));

  // Main sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      offset_q    <= 4'd0;
      level_q     <= 6'd0;
      prev_x_q    <= 8'd0;
      fcnt_q      <= 8'd0;
      stop_pend_q <= 1'b0;
      step_q      <= 1'b0;
      plot_q      <= 1'b0;
      cee_q       <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q  <= ST_DRAW;
            level_q  <= 6'd0;
            offset_q <= 4'd0;
            plot_q   <= 1'b1;
            cee_q    <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ST_DRAW, ST_ERASE: begin
          if (stop_rise) stop_pend_q <= 1'b1;
          if (last_pix) begin
            offset_q <= 4'd0;
            plot_q   <= 1'b0;
            cee_q    <= 1'b0;
            if (state_q == ST_DRAW) begin
              state_q <= ST_WAIT;
            end else begin
              // Step lands between old-x erase and new-x redraw.
              state_q <= ST_STEP;
              step_q  <= 1'b1;
            end
          end else begin
            offset_q <= offset_q + 4'd1;
          end
        end
        ST_STEP: begin
          if (stop_rise) stop_pend_q <= 1'b1;
          state_q  <= ST_DRAW;
          offset_q <= 4'd0;
          plot_q   <= 1'b1;
          cee_q    <= 1'b0;
        end
        ST_WAIT: begin
          // A stop beats a coincident frame tick; the tick is dropped.
          if (stop_pend_q || stop_rise) begin
            state_q <= ST_LOCK;
          end else if (bus.frame_tick) begin
            if (fcnt_inc >= {1'b0, speed}) begin
              fcnt_q   <= 8'd0;
              state_q  <= ST_ERASE;
              offset_q <= 4'd0;
              plot_q   <= 1'b1;
              cee_q    <= 1'b1;
            end else begin
              fcnt_q <= fcnt_inc[7:0];
            end
          end
        end
        ST_LOCK: begin
          stop_pend_q <= 1'b0;
          if (aligned && (level_q == 6'(MAX_LEVEL))) begin
            win_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_END;
          end else if (aligned) begin
            prev_x_q <= bus.x_curr;
            level_q  <= level_q + 6'd1;
            state_q  <= ST_DRAW;
            offset_q <= 4'd0;
            plot_q   <= 1'b1;
            cee_q    <= 1'b0;
          end else begin
            game_over_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_END;
          end
        end
        ST_END: begin
          if (start_rise) begin
            level_q     <= 6'd0;
            prev_x_q    <= 8'd0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            state_q     <= ST_DRAW;
            offset_q    <= 4'd0;
            plot_q      <= 1'b1;
            cee_q       <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.step                = step_q;
  assign bus.colour_erase_enable = cee_q;
  assign bus.plot                = plot_q;
  assign bus.offset              = offset_q;
  assign bus.curr_level          = level_q;
  assign bus.game_over           = game_over_q;
  assign bus.win                 = win_q;
  assign bus.busy                = busy_q;

endmodule

// File: tb/tb_stack_control.sv
// Bench for stack_control: two instances (SPEED_INIT=3/MAX_LEVEL=2 and
// SPEED_INIT=8/MAX_LEVEL=29) share one directed stimulus stream.
module tb_stack_control;

  localparam int P_IDLE  = 0;
  localparam int P_DRAW  = 1;
  localparam int P_WAIT  = 2;
  localparam int P_ERASE = 3;
  localparam int P_STEP  = 4;
  localparam int P_LOCK  = 5;
  localparam int P_END   = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       stop_btn;
  logic       frame_tick;
  logic [7:0] x_curr;

  int n_assert = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  stack_if bus0 ();
  stack_if bus1 ();

  assign bus0.start      = start;
  assign bus0.stop_btn   = stop_btn;
  assign bus0.frame_tick = frame_tick;
  assign bus0.x_curr     = x_curr;
  assign bus1.start      = start;
  assign bus1.stop_btn   = stop_btn;
  assign bus1.frame_tick = frame_tick;
  assign bus1.x_curr     = x_curr;

  stack_control #(.SPEED_INIT(3), .MAX_LEVEL(2)) dut0 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus0)
  );

  stack_control #(.SPEED_INIT(8), .MAX_LEVEL(29)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  // ---------------- behavioural model ----------------
  int m_ph[2], m_pix[2], m_lvl[2], m_px[2], m_fc[2];
  bit m_pend[2], m_go[2], m_win[2];
  bit hs1, hs2, ht1, ht2;

  function automatic int sp_init(input int i);
    return (i == 0) ? 3 : 8;
  endfunction

  function automatic int max_lv(input int i);
    return (i == 0) ? 2 : 29;
  endfunction

  task automatic model_step(input int i, input bit srise, input bit trise);
    int spd;
    spd = sp_init(i) - m_lvl[i];
    if (spd < 1) spd = 1;
    case (m_ph[i])
      P_IDLE: if (start) begin m_ph[i] = P_DRAW; m_pix[i] = 0; end
      P_DRAW, P_ERASE: begin
        if (srise) m_pend[i] = 1'b1;
        if (m_pix[i] == 15) begin
          m_ph[i]  = (m_ph[i] == P_DRAW) ? P_WAIT : P_STEP;
          m_pix[i] = 0;
        end else m_pix[i]++;
      end
      P_STEP: begin
        if (srise) m_pend[i] = 1'b1;
        m_ph[i] = P_DRAW; m_pix[i] = 0;
      end
      P_WAIT: begin
        if (m_pend[i] || srise) m_ph[i] = P_LOCK;
        else if (frame_tick) begin
          if (m_fc[i] + 1 >= spd) begin
            m_fc[i] = 0; m_ph[i] = P_ERASE; m_pix[i] = 0;
          end else m_fc[i]++;
        end
      end
      P_LOCK: begin
        m_pend[i] = 1'b0;
        if (m_lvl[i] == 0 || int'(x_curr) == m_px[i]) begin
          if (m_lvl[i] == max_lv(i)) begin m_win[i] = 1'b1; m_ph[i] = P_END; end
          else begin
            m_px[i] = int'(x_curr); m_lvl[i]++; m_ph[i] = P_DRAW; m_pix[i] = 0;
          end
        end else begin
          m_go[i] = 1'b1; m_ph[i] = P_END;
        end
      end
      P_END: if (trise) begin
        m_lvl[i] = 0; m_go[i] = 1'b0; m_win[i] = 1'b0; m_px[i] = 0;
        m_ph[i] = P_DRAW; m_pix[i] = 0;
      end
      default: m_ph[i] = P_IDLE;
    endcase
  endtask

  always @(posedge clk or negedge resetn) begin
    bit srise, trise;
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = P_IDLE; m_pix[i] = 0; m_lvl[i] = 0; m_px[i] = 0; m_fc[i] = 0;
        m_pend[i] = 1'b0; m_go[i] = 1'b0; m_win[i] = 1'b0;
      end
      hs1 = 1'b0; hs2 = 1'b0; ht1 = 1'b0; ht2 = 1'b0;
    end else begin
      srise = hs1 & ~hs2;
      trise = ht1 & ~ht2;
      hs2 = hs1; hs1 = stop_btn;
      ht2 = ht1; ht1 = start;
      for (int i = 0; i < 2; i++) model_step(i, srise, trise);
    end
  end

  function automatic logic [15:0] exp_vec(input int i);
    logic pl, ce, st, bz;
    logic [3:0] of;
    pl = (m_ph[i] == P_DRAW) || (m_ph[i] == P_ERASE);
    ce = (m_ph[i] == P_ERASE);
    st = (m_ph[i] == P_STEP);
    bz = (m_ph[i] != P_IDLE) && (m_ph[i] != P_END);
    of = pl ? 4'(m_pix[i]) : 4'd0;
    return {pl, ce, st, of, 6'(m_lvl[i]), m_go[i], m_win[i], bz};
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [15:0] act;
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0)
          act = {bus0.plot, bus0.colour_erase_enable, bus0.step, bus0.offset,
                 bus0.curr_level, bus0.game_over, bus0.win, bus0.busy};
        else
          act = {bus1.plot, bus1.colour_erase_enable, bus1.step, bus1.offset,
                 bus1.curr_level, bus1.game_over, bus1.win, bus1.busy};
        n_assert++;
        if (act !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL model_cmp dut%0d t=%0t actual=%h required=%h", i, $time, act, exp_vec(i));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic press_stop(input logic [7:0] x);
    x_curr = x; stop_btn = 1'b1; cyc(3); stop_btn = 1'b0; cyc(22);
  endtask

  initial begin
    int n_er, n_dr, n_st, st_idx, lv_idx;
    resetn = 1'b0; start = 1'b0; stop_btn = 1'b0; frame_tick = 1'b0; x_curr = 8'd0;
    cyc(3);
    check("rst_plot", int'(bus0.plot), 0);
    check("rst_busy", int'(bus0.busy), 0);
    check("rst_level", int'(bus0.curr_level), 0);
    check("rst_step", int'(bus1.step), 0);
    resetn = 1'b1; cmp_en = 1'b1;
    cyc(2);

    // New game: 16 draw pixels, offsets 0..15.
    start = 1'b1; cyc(1); start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("draw_off", int'(bus0.offset), k);
      check("draw_plot", int'(bus0.plot & ~bus0.colour_erase_enable), 1);
      cyc(1);
    end
    check("wait_noplot", int'(bus0.plot), 0);
    cyc(3);

    // Three ticks at speed 3: no step before the third.
    for (int t = 0; t < 3; t++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      check("no_early_step", int'(bus0.step), 0);
      if (t < 2) check("still_wait", int'(bus0.plot), 0);
      cyc(1);
    end
    n_er = 0; n_dr = 0; n_st = 0; st_idx = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus0.plot && bus0.colour_erase_enable) n_er++;
      if (bus0.plot && !bus0.colour_erase_enable) n_dr++;
      if (bus0.step) begin n_st++; st_idx = k; end
      cyc(1);
    end
    // First erase pixel was seen one cycle before the loop started.
    check("erase_cnt", n_er, 15);
    check("draw_cnt", n_dr, 16);
    check("step_cnt", n_st, 1);
    check("step_pos", st_idx, 15);

    // Aligned locks then a misaligned one.
    press_stop(8'd40);
    check("lvl1_d0", int'(bus0.curr_level), 1);
    check("lvl1_d1", int'(bus1.curr_level), 1);
    press_stop(8'd40);
    check("lvl2_d0", int'(bus0.curr_level), 2);
    press_stop(8'd44);
    check("gover_d0", int'(bus0.game_over), 1);
    check("gover_busy", int'(bus0.busy), 0);
    check("gover_win", int'(bus0.win), 0);
    check("gover_d1", int'(bus1.game_over), 1);

    // Restart from END.
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    check("restart_plot", int'(bus0.plot), 1);
    check("restart_lvl", int'(bus0.curr_level), 0);
    check("restart_go", int'(bus0.game_over), 0);
    cyc(20);

    // Stop during ERASE: lock only after step and redraw.
    x_curr = 8'd40;
    for (int t = 0; t < 3; t++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; if (t < 2) cyc(1);
    end
    cyc(4);
    check("mid_erase_off", int'(bus0.offset), 4);
    stop_btn = 1'b1; cyc(2); stop_btn = 1'b0;
    st_idx = -1; lv_idx = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus0.step && st_idx < 0) st_idx = k;
      if (bus0.curr_level == 6'd1 && lv_idx < 0) lv_idx = k;
      cyc(1);
    end
    check("pend_step_idx", st_idx, 10);
    check("pend_lock_idx", lv_idx, 29);
    cyc(10);

    // Two more aligned locks on the MAX_LEVEL=2 instance: win.
    press_stop(8'd40);
    press_stop(8'd40);
    check("win_flag", int'(bus0.win), 1);
    check("win_level", int'(bus0.curr_level), 2);
    check("win_busy", int'(bus0.busy), 0);
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    check("win_restart_lvl", int'(bus0.curr_level), 0);
    check("win_restart_flag", int'(bus0.win), 0);
    check("win_restart_plot", int'(bus0.plot), 1);
    cyc(20);

    // Climb the second instance to level 10 (speed floor of 1).
    repeat (7) press_stop(8'd40);
    check("lvl10_d1", int'(bus1.curr_level), 10);
    for (int t = 0; t < 2; t++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      n_st = 0;
      for (int k = 0; k < 40; k++) begin
        if (bus1.step) n_st++;
        cyc(1);
      end
      check("speed1_step", n_st, 1);
    end

    // Async reset in the middle of a draw.
    resetn = 1'b0; cyc(2); resetn = 1'b1; cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(7);
    check("pre_rst_off", int'(bus0.offset), 7);
    resetn = 1'b0; #1;
    check("async_plot0", int'(bus0.plot), 0);
    check("async_plot1", int'(bus1.plot), 0);
    check("async_busy", int'(bus0.busy), 0);
    check("async_off", int'(bus0.offset), 0);
    cyc(2);
    resetn = 1'b1;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
